// File: rtl/sha256_padder.sv
// SHA-256 message padder: streams 32-bit message words in, emits 512-bit padded blocks.
// Define SHA256_PADDER_BLKCNT_EN to expose blk_total / blk_idx block-count outputs.
module sha256_padder #(
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [511:0]     out_block,
  output logic             out_last,
  output logic             busy,
  output logic             done
`ifdef SHA256_PADDER_BLKCNT_EN
  ,
  output logic [1:0]       blk_total,
  output logic [1:0]       blk_idx
`endif
);

  localparam int BLK_W = LEN_W - 8;
  localparam int CNT_W = LEN_W - 4;

  typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

  state_t           state_reg, state_next;
  logic [LEN_W-1:0] len_reg;
  logic [CNT_W-1:0] n_words_reg;
  logic [BLK_W-1:0] n_blk_reg;
  logic [BLK_W-1:0] blk_cnt_reg;
  logic [4:0]       slot_reg;
  logic [511:0]     blk_reg;
  logic             done_reg;

  logic [CNT_W-1:0] abs_idx;
  logic             words_left;
  logic             last_blk;
  logic             pad_here;
  logic [31:0]      word_mask;

  // Absolute word index of the slot being filled; a full block (slot 16) never takes more words.
  assign abs_idx    = {blk_cnt_reg, slot_reg[3:0]};
  assign words_left = !slot_reg[4] && (abs_idx < n_words_reg);
  assign last_blk   = (blk_cnt_reg == n_blk_reg - BLK_W'(1));
  assign pad_here   = (blk_cnt_reg == {1'b0, len_reg[LEN_W-1:9]});
  assign word_mask  = (abs_idx == {1'b0, len_reg[LEN_W-1:5]}) ?
                      ~(32'hFFFF_FFFF >> len_reg[4:0]) : 32'hFFFF_FFFF;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      len_reg     <= '0;
      n_words_reg <= '0;
      n_blk_reg   <= '0;
      blk_cnt_reg <= '0;
      slot_reg    <= '0;
      blk_reg     <= '0;
      done_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            len_reg     <= msg_len;
            n_words_reg <= CNT_W'(({1'b0, msg_len} + (LEN_W+1)'(31)) >> 5);
            n_blk_reg   <= BLK_W'((({1'b0, msg_len} + (LEN_W+1)'(64)) >> 9) + (LEN_W+1)'(1));
            blk_cnt_reg <= '0;
            slot_reg    <= '0;
            blk_reg     <= '0;
          end
        end
        LOAD: begin
          if (in_ready && in_valid) begin
            blk_reg[{~slot_reg[3:0], 5'h1f} -: 32] <= in_data & word_mask;
            slot_reg <= slot_reg + 5'd1;
          end else if (!words_left) begin
            // Pad bit index inside the block is 511 - (msg_len mod 512).
            if (pad_here) blk_reg[~len_reg[8:0]] <= 1'b1;
            if (last_blk) blk_reg[63:0] <= 64'(len_reg);
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (last_blk) begin
              done_reg <= 1'b1;
            end else begin
              blk_cnt_reg <= blk_cnt_reg + BLK_W'(1);
              slot_reg    <= '0;
              blk_reg     <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    case (state_reg)
      IDLE: if (start) state_next = LOAD;
      LOAD: begin
        in_ready = words_left;
        if (!words_left) state_next = EMIT;
      end
      EMIT: if (out_ready) state_next = last_blk ? IDLE : LOAD;
      default: state_next = IDLE;
    endcase
  end

  assign out_valid = (state_reg == EMIT);
  assign out_last  = out_valid && last_blk;
  assign out_block = blk_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;

`ifdef SHA256_PADDER_BLKCNT_EN
  assign blk_total = 2'(n_blk_reg);
  assign blk_idx   = 2'(blk_cnt_reg);
`endif

endmodule
